// File: rtl/vscale_xvec_red_ctrl.sv
// Cross-lane vector reduction controller that folds a captured operand vector through the shared vscale ALU.
// Optional signed MIN/MAX reductions are enabled by defining XVEC_RED_MINMAX_EN.

`ifndef XVEC_VEC_LEN
`define XVEC_VEC_LEN 29
`endif
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 4'd0
`endif
`ifndef ALU_OP_XOR
`define ALU_OP_XOR 4'd4
`endif
`ifndef ALU_OP_OR
`define ALU_OP_OR 4'd6
`endif
`ifndef ALU_OP_AND
`define ALU_OP_AND 4'd7
`endif
`ifndef ALU_OP_SLT
`define ALU_OP_SLT 4'd12
`endif

module vscale_xvec_red_ctrl #(
   parameter int unsigned VEC_LEN = `XVEC_VEC_LEN,
   parameter int unsigned XPR_LEN = `XPR_LEN
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [2:0]                 req_op,
   input  logic [4:0]                 req_vl,
   input  logic [VEC_LEN*XPR_LEN-1:0] req_vec,
   output logic                       alu_req,
   input  logic                       alu_gnt,
   output logic [`ALU_OP_WIDTH-1:0]   alu_op,
   output logic [XPR_LEN-1:0]         alu_in1,
   output logic [XPR_LEN-1:0]         alu_in2,
   input  logic [XPR_LEN-1:0]         alu_out,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [XPR_LEN-1:0]         resp_data,
   output logic                       resp_err
);

   localparam int unsigned IDX_W = 5;
   localparam int unsigned AOP_W = `ALU_OP_WIDTH;
   localparam int unsigned VEC_W = VEC_LEN * XPR_LEN;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_AND = 3'd1;
   localparam logic [2:0] OP_OR  = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
`ifdef XVEC_RED_MINMAX_EN
   localparam logic [2:0] OP_MIN = 3'd4;
   localparam logic [2:0] OP_MAX = 3'd5;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [VEC_W-1:0]     vec_q, vec_d;
   logic [2:0]           op_q, op_d;
   logic [IDX_W-1:0]     vl_last_q, vl_last_d;
   logic [IDX_W-1:0]     vl_eff;
   logic [XPR_LEN-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 req_ready_d;
   logic                 resp_valid_d;
   logic                 resp_err_d;
   logic [XPR_LEN-1:0]   resp_data_d;
   logic                 alu_req_d;
   logic [AOP_W-1:0]     alu_op_d;
   logic [XPR_LEN-1:0]   alu_in1_d;
   logic [XPR_LEN-1:0]   alu_in2_d;

   // Lane extraction; indices past the vector return zero.
   function automatic logic [XPR_LEN-1:0] lane_of(input logic [VEC_W-1:0] vec,
                                                  input logic [IDX_W-1:0] idx);
      logic [XPR_LEN-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < VEC_LEN; i++) begin
         if (idx == IDX_W'(i)) r = vec[i*XPR_LEN +: XPR_LEN];
      end
      return r;
   endfunction

   function automatic logic op_legal(input logic [2:0] op);
      logic ok;
      case (op)
         OP_ADD, OP_AND, OP_OR, OP_XOR: ok = 1'b1;
`ifdef XVEC_RED_MINMAX_EN
         OP_MIN, OP_MAX:                ok = 1'b1;
`endif
         default:                       ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [AOP_W-1:0] alu_code(input logic [2:0] op);
      logic [AOP_W-1:0] c;
      case (op)
         OP_AND:  c = AOP_W'(`ALU_OP_AND);
         OP_OR:   c = AOP_W'(`ALU_OP_OR);
         OP_XOR:  c = AOP_W'(`ALU_OP_XOR);
`ifdef XVEC_RED_MINMAX_EN
         OP_MIN,
         OP_MAX:  c = AOP_W'(`ALU_OP_SLT);
`endif
         default: c = AOP_W'(`ALU_OP_ADD);
      endcase
      return c;
   endfunction

   // Result for an empty reduction: the neutral element of the operator.
   function automatic logic [XPR_LEN-1:0] identity(input logic [2:0] op);
      logic [XPR_LEN-1:0] v;
      case (op)
         OP_AND:  v = '1;
`ifdef XVEC_RED_MINMAX_EN
         OP_MIN:  v = {1'b0, {(XPR_LEN-1){1'b1}}};
         OP_MAX:  v = {1'b1, {(XPR_LEN-1){1'b0}}};
`endif
         default: v = '0;
      endcase
      return v;
   endfunction

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      op_d         = op_q;
      vl_last_d    = vl_last_q;
      vl_eff       = '0;
      acc_d        = acc_q;
      idx_d        = idx_q;
      resp_valid_d = resp_valid;
      resp_err_d   = resp_err;
      resp_data_d  = resp_data;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               vl_eff    = (32'(req_vl) > VEC_LEN) ? IDX_W'(VEC_LEN) : req_vl;
               vec_d     = req_vec;
               op_d      = req_op;
               vl_last_d = vl_eff - IDX_W'(1);
               acc_d     = lane_of(req_vec, IDX_W'(0));
               idx_d     = IDX_W'(1);
               if (!op_legal(req_op)) begin
                  state_d      = S_DONE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_data_d  = '0;
               end else if (vl_eff == IDX_W'(0)) begin
                  state_d      = S_DONE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b0;
                  resp_data_d  = identity(req_op);
               end else if (vl_eff == IDX_W'(1)) begin
                  state_d      = S_DONE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b0;
                  resp_data_d  = lane_of(req_vec, IDX_W'(0));
               end else begin
                  state_d      = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (alu_gnt) begin
               case (op_q)
`ifdef XVEC_RED_MINMAX_EN
                  // SLT(acc, lane) picks which operand survives.
                  OP_MIN:  acc_d = alu_out[0] ? acc_q : lane_of(vec_q, idx_q);
                  OP_MAX:  acc_d = alu_out[0] ? lane_of(vec_q, idx_q) : acc_q;
`endif
                  default: acc_d = alu_out;
               endcase
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == vl_last_q) begin
                  state_d      = S_DONE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b0;
                  resp_data_d  = acc_d;
               end
            end
         end
         S_DONE: begin
            if (resp_ready) begin
               state_d      = S_IDLE;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_data_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      req_ready_d = (state_d == S_IDLE);
      alu_req_d   = (state_d == S_RUN);
      alu_op_d    = AOP_W'(`ALU_OP_ADD);
      alu_in1_d   = '0;
      alu_in2_d   = '0;
      if (state_d == S_RUN) begin
         alu_op_d  = alu_code(op_d);
         alu_in1_d = acc_d;
         alu_in2_d = lane_of(vec_d, idx_d);
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         vec_q      <= '0;
         op_q       <= OP_ADD;
         vl_last_q  <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_data  <= '0;
         alu_req    <= 1'b0;
         alu_op     <= AOP_W'(`ALU_OP_ADD);
         alu_in1    <= '0;
         alu_in2    <= '0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         op_q       <= op_d;
         vl_last_q  <= vl_last_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         resp_err   <= resp_err_d;
         resp_data  <= resp_data_d;
         alu_req    <= alu_req_d;
         alu_op     <= alu_op_d;
         alu_in1    <= alu_in1_d;
         alu_in2    <= alu_in2_d;
      end
   end

endmodule
